bpu_ctrl: RTL and testbench
===========================

BPU_CTRL -- requirements
Module: bpu_ctrl

Interface
REQ-001 Parameter WGT_BITS, default 49: serial weight length per kernel (7x7).
REQ-002 Parameter WIN_W, default 8: width of window-count field.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 k_valid  in  1  kernel word offered.
REQ-006 k_ready  out  1  kernel word accepted when k_valid&k_ready.
REQ-007 k_data  in  WGT_BITS  kernel bits; bit WGT_BITS-1 shifted out first.
REQ-008 start  in  1  single-cycle request to run a job.
REQ-009 cfg_height  in  3  rows per window (0..7), sampled on start.
REQ-010 cfg_shift  in  3  image right-shift, sampled on start.
REQ-011 cfg_nwin  in  WIN_W  windows per job, sampled on start; 0 means no windows.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 wgt_input  out  1  serial weight bit to BPU.
REQ-014 wgt_en  out  1  weight shift enable to BPU.
REQ-015 instruction  out  5  [0] psum_rst, [3:1] lut_sel, [4] psum_add, to BPU.
REQ-016 height  out  3  registered copy of cfg_height.
REQ-017 right_shift  out  3  registered copy of cfg_shift.
REQ-018 popcnt_add  in  7  signed accumulated result from BPU.
REQ-019 img_adv  out  1  one-cycle pulse: upstream may present the next window image.
REQ-020 res_valid / res_ready  out / in  1  result handshake.
REQ-021 res_data  out  7  signed window result, held stable while res_valid&!res_ready.
REQ-022 job_done  out  1  one-cycle pulse after the last window's result transfers.

Function
REQ-023 States SHALL be IDLE, LOAD, CLR, RUN, CAPT, OUT.
REQ-024 IDLE: k_ready=1. k_valid SHALL take priority over start if both arrive in the same cycle: LOAD is entered and start is dropped.
REQ-025 LOAD: k_data SHALL be latched into a shift register on acceptance; for exactly WGT_BITS cycles, wgt_en=1 and wgt_input=current MSB, shifting left each cycle; then return to IDLE; k_ready=0 in LOAD.
REQ-026 start in IDLE with cfg_nwin!=0: latch cfg; win_cnt=cfg_nwin; go to CLR. With cfg_nwin==0: pulse job_done next cycle and stay in IDLE.
REQ-027 CLR (1 cycle): instruction=5'b00001.
REQ-028 RUN lasts height+1 cycles, indexed k=0..height: lut_sel=k when k<height, else 0; psum_add=1 when k>=1, else 0; psum_rst=0.
REQ-029 height=0: RUN SHALL last 1 cycle with instruction=0; the result is whatever popcnt_add holds after CLR (0).
REQ-030 CAPT (1 cycle): res_data<=popcnt_add; img_adv=1; instruction=0; go to OUT.
REQ-031 OUT: res_valid=1 until res_ready. On transfer, decrement win_cnt; go to CLR if win_cnt was >1; otherwise pulse job_done and go to IDLE.
REQ-032 Per window, cycles from CLR entry to res_valid rising SHALL be height+3.
REQ-033 wgt_en SHALL be 0 outside LOAD; instruction SHALL be 0 in IDLE, LOAD and OUT.
REQ-034 start or k_valid while busy SHALL be ignored; the kernel is not accepted (k_ready=0).
REQ-035 height and right_shift SHALL stay constant from start until the job ends.

Reset
REQ-036 rst SHALL force IDLE; outputs clear: k_ready=1 from the first cycle after reset, busy=0, wgt_en=0, wgt_input=0, instruction=0, height=0, right_shift=0, img_adv=0, res_valid=0, res_data=0, job_done=0; counters clear.
REQ-037 rst asserted mid-LOAD or mid-job SHALL abort it; no res_valid or job_done follows.

Verification
REQ-038 Kernel load: k_data=49'h1_0000_0000_0001 accepted -> wgt_en high for 49 cycles; wgt_input=1 on cycles 0 and 48 only; k_ready=0 during LOAD.
REQ-039 Single window: height=7, nwin=1, BPU model present -> instruction sequence 01, then lut_sel 0..6 with psum_add on cycles 1..7; res_valid at CLR+10; res_data equals model popcnt_add; job_done pulse.
REQ-040 Backpressure: nwin=3, res_ready low for 5 cycles on window 2 -> res_data stable; exactly 3 transfers; 3 img_adv pulses; one job_done.
REQ-041 Boundary: height=0 -> res_data=0 at CLR+3; nwin=0 -> job_done only, busy never set.
REQ-042 Conflict/reset: k_valid and start in the same cycle -> LOAD taken, start dropped; rst on RUN cycle 3 -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/bpu_ctrl.sv
// Sequencer for a bit-serial BPU: loads 7x7 kernel weights serially and steps the
// BPU through clear / per-row accumulate / capture for each window of a job.
module bpu_ctrl #(
    parameter int unsigned WGT_BITS = 49,
    parameter int unsigned WIN_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       k_valid,
    output logic                       k_ready,
    input  logic [WGT_BITS-1:0]        k_data,
    input  logic                       start,
    input  logic [2:0]                 cfg_height,
    input  logic [2:0]                 cfg_shift,
    input  logic [WIN_W-1:0]           cfg_nwin,
    output logic                       busy,
    output logic                       wgt_input,
    output logic                       wgt_en,
    output logic [4:0]                 instruction,
    output logic [2:0]                 height,
    output logic [2:0]                 right_shift,
    input  logic signed [6:0]          popcnt_add,
    output logic                       img_adv,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [6:0]          res_data,
    output logic                       job_done
);

    localparam int unsigned CW = ($clog2(WGT_BITS) > 3) ? $clog2(WGT_BITS) : 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        RUN,
        CAPT,
        OUT
    } state_t;

    state_t                state_q, state_d;
    logic [WGT_BITS-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [2:0]            height_q, height_d;
    logic [2:0]            shift_q, shift_d;
    logic signed [6:0]     res_data_q, res_data_d;
    logic                  k_ready_q, k_ready_d;
    logic                  busy_q, busy_d;
    logic                  wgt_en_q, wgt_en_d;
    logic                  wgt_input_q, wgt_input_d;
    logic [4:0]            instr_q, instr_d;
    logic                  img_adv_q, img_adv_d;
    logic                  res_valid_q, res_valid_d;
    logic                  job_done_q, job_done_d;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        win_cnt_d  = win_cnt_q;
        height_d   = height_q;
        shift_d    = shift_q;
        res_data_d = res_data_q;
        job_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A kernel offer wins over a simultaneous start; the start is lost.
                if (k_valid) begin
                    state_d = LOAD;
                    shreg_d = k_data;
                    cnt_d   = '0;
                end else if (start) begin
                    if (cfg_nwin != '0) begin
                        height_d  = cfg_height;
                        shift_d   = cfg_shift;
                        win_cnt_d = cfg_nwin;
                        state_d   = CLR;
                    end else begin
                        job_done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == CW'(WGT_BITS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CLR: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                if (cnt_q == CW'(height_q)) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CAPT: begin
                res_data_d = popcnt_add;
                state_d    = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                    if (win_cnt_q > WIN_W'(1)) begin
                        state_d = CLR;
                    end else begin
                        job_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up
        // with the state they belong to.
        k_ready_d   = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        wgt_en_d    = (state_d == LOAD);
        wgt_input_d = wgt_en_d & shreg_d[WGT_BITS-1];
        img_adv_d   = (state_d == CAPT);
        res_valid_d = (state_d == OUT);

        instr_d = '0;
        if (state_d == CLR) begin
            instr_d = 5'b00001;
        end else if (state_d == RUN) begin
            instr_d[4]   = (cnt_d != '0);
            instr_d[3:1] = (cnt_d < CW'(height_d)) ? cnt_d[2:0] : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            win_cnt_q   <= '0;
            height_q    <= '0;
            shift_q     <= '0;
            res_data_q  <= '0;
            k_ready_q   <= 1'b1;
            busy_q      <= 1'b0;
            wgt_en_q    <= 1'b0;
            wgt_input_q <= 1'b0;
            instr_q     <= '0;
            img_adv_q   <= 1'b0;
            res_valid_q <= 1'b0;
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            win_cnt_q   <= win_cnt_d;
            height_q    <= height_d;
            shift_q     <= shift_d;
            res_data_q  <= res_data_d;
            k_ready_q   <= k_ready_d;
            busy_q      <= busy_d;
            wgt_en_q    <= wgt_en_d;
            wgt_input_q <= wgt_input_d;
            instr_q     <= instr_d;
            img_adv_q   <= img_adv_d;
            res_valid_q <= res_valid_d;
            job_done_q  <= job_done_d;
        end
    end

    assign k_ready     = k_ready_q;
    assign busy        = busy_q;
    assign wgt_en      = wgt_en_q;
    assign wgt_input   = wgt_input_q;
    assign instruction = instr_q;
    assign height      = height_q;
    assign right_shift = shift_q;
    assign img_adv     = img_adv_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign job_done    = job_done_q;

endmodule

// File: tb/tb_bpu_ctrl.sv
// Directed bench for bpu_ctrl with a small BPU accumulator model driving popcnt_add.
module tb_bpu_ctrl;

    localparam int unsigned WGT_BITS = 49;
    localparam int unsigned WIN_W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                k_valid;
    logic                k_ready;
    logic [WGT_BITS-1:0] k_data;
    logic                start;
    logic [2:0]          cfg_height;
    logic [2:0]          cfg_shift;
    logic [WIN_W-1:0]    cfg_nwin;
    logic                busy;
    logic                wgt_input;
    logic                wgt_en;
    logic [4:0]          instruction;
    logic [2:0]          height;
    logic [2:0]          right_shift;
    logic [6:0]          psum_q;
    logic                img_adv;
    logic                res_valid;
    logic                res_ready;
    logic [6:0]          res_data;
    logic                job_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_xfer, n_adv, n_done;

    // RUN-phase instruction expected on each cycle after CLR entry, height = 7.
    logic [4:0] exp_instr [11] = '{5'h01, 5'h00, 5'h12, 5'h14, 5'h16, 5'h18,
                                   5'h1a, 5'h1c, 5'h10, 5'h00, 5'h00};

    bpu_ctrl #(.WGT_BITS(WGT_BITS), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst(rst),
        .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .start(start), .cfg_height(cfg_height), .cfg_shift(cfg_shift), .cfg_nwin(cfg_nwin),
        .busy(busy), .wgt_input(wgt_input), .wgt_en(wgt_en), .instruction(instruction),
        .height(height), .right_shift(right_shift), .popcnt_add(psum_q),
        .img_adv(img_adv), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .job_done(job_done)
    );

    always #5 clk = ~clk;

    // BPU model: lut value 3*sel - 8 + image index, added one cycle after selection.
    int         img_id;
    logic [6:0] lut_q;
    always @(posedge clk) begin
        if (rst) begin
            lut_q  <= '0;
            psum_q <= '0;
            img_id <= 0;
        end else begin
            lut_q <= 7'(3 * int'(instruction[3:1]) - 8 + img_id);
            if (instruction[0])      psum_q <= '0;
            else if (instruction[4]) psum_q <= psum_q + lut_q;
            if (img_adv) img_id <= img_id + 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            n_xfer <= 0;
            n_adv  <= 0;
            n_done <= 0;
        end else begin
            if (res_valid && res_ready) n_xfer <= n_xfer + 1;
            if (img_adv)                n_adv  <= n_adv + 1;
            if (job_done)               n_done <= n_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".k_ready"}, k_ready, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".wgt_en"}, wgt_en, 0);
        chk({tag, ".wgt_input"}, wgt_input, 0);
        chk({tag, ".instruction"}, instruction, 0);
        chk({tag, ".height"}, height, 0);
        chk({tag, ".right_shift"}, right_shift, 0);
        chk({tag, ".img_adv"}, img_adv, 0);
        chk({tag, ".res_valid"}, res_valid, 0);
        chk({tag, ".res_data"}, res_data, 0);
        chk({tag, ".job_done"}, job_done, 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && res_valid !== 1'b1; i++) @(negedge clk);
        chk({tag, ".valid_seen"}, res_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; k_valid = 1'b0; k_data = '0; start = 1'b0;
        cfg_height = '0; cfg_shift = '0; cfg_nwin = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("post_rst");

        // Kernel load: MSB and LSB set -> wgt_input high on first and last LOAD cycle.
        k_valid = 1'b1; k_data = 49'h1_0000_0000_0001;
        @(negedge clk);
        k_valid = 1'b0; k_data = '0;
        for (int i = 0; i < 49; i++) begin
            chk("load.wgt_en", wgt_en, 1);
            chk("load.wgt_input", wgt_input, (i == 0 || i == 48));
            chk("load.k_ready", k_ready, 0);
            @(negedge clk);
        end
        chk("load.end.wgt_en", wgt_en, 0);
        chk("load.end.k_ready", k_ready, 1);
        chk("load.end.busy", busy, 0);

        // Single window, height 7; cfg changes and busy-time requests must be ignored.
        cfg_height = 3'd7; cfg_shift = 3'd5; cfg_nwin = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_height = 3'd2; cfg_shift = 3'd1; cfg_nwin = 8'd4;
        chk("win1.clr.instr", instruction, exp_instr[0]);
        chk("win1.busy", busy, 1);
        chk("win1.height", height, 7);
        chk("win1.right_shift", right_shift, 5);
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) begin
                k_valid = 1'b1; k_data = 49'h1_FFFF_0000_FFFF; start = 1'b1;
            end else begin
                k_valid = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            chk("win1.instr", instruction, exp_instr[c]);
            chk("win1.res_valid", res_valid, (c == 10));
            chk("win1.img_adv", img_adv, (c == 9));
            chk("win1.k_ready", k_ready, 0);
            chk("win1.wgt_en", wgt_en, 0);
            chk("win1.height_hold", height, 7);
        end
        chk("win1.res_data", res_data, 7'h07);
        @(negedge clk);
        chk("win1.job_done", job_done, 1);
        chk("win1.idle_busy", busy, 0);
        chk("win1.idle_valid", res_valid, 0);
        @(negedge clk);
        chk("win1.job_done_pulse", job_done, 0);
        chk("win1.n_xfer", n_xfer, 1);
        chk("win1.n_adv", n_adv, 1);
        chk("win1.n_done", n_done, 1);

        // Backpressure: 3 windows of height 3, result sums -15, -12, -9.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cfg_height = 3'd3; cfg_shift = 3'd2; cfg_nwin = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("bp.w1", 20);
        chk("bp.w1.data", res_data, 7'h71);
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp.w1.done", res_valid, 0);
        wait_valid("bp.w2", 20);
        chk("bp.w2.data", res_data, 7'h74);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("bp.w2.hold_valid", res_valid, 1);
            chk("bp.w2.hold_data", res_data, 7'h74);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp.w2.released", res_valid, 0);
        chk("bp.w2.busy", busy, 1);
        wait_valid("bp.w3", 20);
        chk("bp.w3.data", res_data, 7'h77);
        @(negedge clk);
        chk("bp.job_done", job_done, 1);
        chk("bp.idle", busy, 0);
        @(negedge clk);
        chk("bp.job_done_pulse", job_done, 0);
        chk("bp.n_xfer", n_xfer, 3);
        chk("bp.n_adv", n_adv, 3);
        chk("bp.n_done", n_done, 1);
        chk("bp.height", height, 3);
        chk("bp.right_shift", right_shift, 2);

        // Height 0: one idle RUN cycle; result must come from the cleared psum.
        cfg_height = 3'd0; cfg_nwin = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("h0.clr", instruction, 5'h01);
        @(negedge clk);
        chk("h0.run.instr", instruction, 0);
        chk("h0.run.valid", res_valid, 0);
        @(negedge clk);
        chk("h0.capt.img_adv", img_adv, 1);
        chk("h0.capt.valid", res_valid, 0);
        @(negedge clk);
        chk("h0.out.valid", res_valid, 1);
        chk("h0.out.data", res_data, 0);
        @(negedge clk);
        chk("h0.job_done", job_done, 1);

        // nwin = 0: job_done pulse only.
        cfg_height = 3'd5; cfg_nwin = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nw0.job_done", job_done, 1);
        chk("nw0.busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nw0.after.busy", busy, 0);
            chk("nw0.after.job_done", job_done, 0);
            chk("nw0.after.instr", instruction, 0);
        end

        // k_valid and start together: LOAD wins, start is dropped.
        k_valid = 1'b1; k_data = 49'h0_C000_0000_0000; start = 1'b1;
        cfg_height = 3'd4; cfg_nwin = 8'd2;
        @(negedge clk);
        k_valid = 1'b0; start = 1'b0;
        chk("conf.wgt_en", wgt_en, 1);
        chk("conf.wgt_input0", wgt_input, 0);
        chk("conf.k_ready", k_ready, 0);
        chk("conf.instr", instruction, 0);
        @(negedge clk);
        chk("conf.wgt_input1", wgt_input, 1);
        repeat (48) @(negedge clk);
        chk("conf.end.wgt_en", wgt_en, 0);
        chk("conf.end.busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("conf.dropped.busy", busy, 0);
            chk("conf.dropped.instr", instruction, 0);
        end

        // Reset during RUN cycle k=3 aborts the job.
        cfg_height = 3'd7; cfg_shift = 3'd6; cfg_nwin = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rrun.k3.instr", instruction, 5'h16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("rrun");
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("rrun.after.valid", res_valid, 0);
            chk("rrun.after.job_done", job_done, 0);
            chk("rrun.after.busy", busy, 0);
        end
        chk("rrun.n_done", n_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
